// File: rtl/irq_controller.sv
// Single-hart user-mode interrupt controller: edge-latched sources, fixed priority, vectored entry.
// Define NESTED_IRQ_EN for preemption by higher-priority sources with a return stack and a depth output.
module irq_controller #(
    parameter int          NUM_SRC    = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040,
    localparam int         SRC_W      = $clog2(NUM_SRC),
    localparam int         DEPTH_W    = $clog2(NUM_SRC + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               ie_set,
    input  logic               ie_clr,
    input  logic               uret,
    input  logic               take_ok,
    input  logic [31:0]        pc_commit,
    output logic               irq_take,
    output logic [31:0]        irq_vector,
    output logic [31:0]        epc,
    output logic               ie,
    output logic               in_service,
    output logic [SRC_W-1:0]   cur_src,
    output logic [NUM_SRC-1:0] pending
`ifdef NESTED_IRQ_EN
    ,
    output logic [DEPTH_W-1:0] depth
`endif
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] SERVICE = 1'b1;

    logic [0:0]         state_reg;
    logic [NUM_SRC-1:0] irq_prev_reg;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clear_mask;
    logic               ie_reg;
    logic               ie_next;
    logic               irq_take_reg;
    logic [31:0]        irq_vector_reg;
    logic [31:0]        epc_reg;
    logic [SRC_W-1:0]   cur_src_reg;
    logic [SRC_W-1:0]   sel;
    logic [31:0]        sel_vector;
    logic               take;
    logic               do_uret;

    assign do_uret = uret && (state_reg == SERVICE);

    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                sel = SRC_W'(i);
            end
        end
    end

    assign sel_vector = VEC_BASE + ({{(32 - SRC_W){1'b0}}, sel} * VEC_STRIDE);

`ifdef NESTED_IRQ_EN
    // A return in the same cycle always wins over preemption.
    assign take = ie_reg && take_ok && (|pending_reg) &&
                  ((state_reg == IDLE) || (!uret && (sel < cur_src_reg)));
`else
    assign take = ie_reg && take_ok && (|pending_reg) && (state_reg == IDLE);
`endif

    // A fresh edge arriving while its bit is being cleared must survive.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            assign rise[gi]         = irq_src[gi] & ~irq_prev_reg[gi];
            assign clear_mask[gi]   = take && (sel == SRC_W'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~clear_mask[gi]) | rise[gi];
        end
    endgenerate

    always_comb begin
        ie_next = ie_reg;
        if (do_uret) begin
            ie_next = 1'b1;
        end else if (take) begin
`ifdef NESTED_IRQ_EN
            ie_next = ie_reg;
`else
            ie_next = 1'b0;
`endif
        end else if (ie_clr) begin
            ie_next = 1'b0;
        end else if (ie_set) begin
            ie_next = 1'b1;
        end
    end

`ifdef NESTED_IRQ_EN
    logic [DEPTH_W-1:0]    depth_reg;
    logic [32+SRC_W-1:0]   stack_mem [NUM_SRC];
    logic [SRC_W-1:0]      push_idx;
    logic [SRC_W-1:0]      pop_idx;
    logic [32+SRC_W-1:0]   pop_data;

    assign push_idx = SRC_W'(depth_reg - DEPTH_W'(1));
    assign pop_idx  = SRC_W'(depth_reg - DEPTH_W'(2));
    assign pop_data = stack_mem[pop_idx];
    assign depth    = depth_reg;

    // Only outer levels are saved; the current level lives in epc_reg/cur_src_reg.
    always_ff @(posedge clk) begin
        if (take && (state_reg == SERVICE)) begin
            stack_mem[push_idx] <= {epc_reg, cur_src_reg};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            irq_prev_reg   <= '0;
            pending_reg    <= '0;
            ie_reg         <= 1'b0;
            irq_take_reg   <= 1'b0;
            irq_vector_reg <= '0;
            epc_reg        <= '0;
            cur_src_reg    <= '0;
`ifdef NESTED_IRQ_EN
            depth_reg      <= '0;
`endif
        end else begin
            irq_prev_reg <= irq_src;
            pending_reg  <= pending_next;
            ie_reg       <= ie_next;
            irq_take_reg <= take;
            if (take) begin
                irq_vector_reg <= sel_vector;
                epc_reg        <= pc_commit;
                cur_src_reg    <= sel;
                state_reg      <= SERVICE;
`ifdef NESTED_IRQ_EN
                if (state_reg == SERVICE) begin
                    depth_reg <= depth_reg + DEPTH_W'(1);
                end else begin
                    depth_reg <= DEPTH_W'(1);
                end
`endif
            end else if (do_uret) begin
`ifdef NESTED_IRQ_EN
                if (depth_reg <= DEPTH_W'(1)) begin
                    state_reg <= IDLE;
                    depth_reg <= '0;
                end else begin
                    epc_reg     <= pop_data[32+SRC_W-1:SRC_W];
                    cur_src_reg <= pop_data[SRC_W-1:0];
                    depth_reg   <= depth_reg - DEPTH_W'(1);
                end
`else
                state_reg <= IDLE;
`endif
            end
        end
    end

    assign irq_take   = irq_take_reg;
    assign irq_vector = irq_vector_reg;
    assign epc        = epc_reg;
    assign ie         = ie_reg;
    assign in_service = (state_reg == SERVICE);
    assign cur_src    = cur_src_reg;
    assign pending    = pending_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller; each task drives one scenario and checks inline.
module tb_irq_controller;

    logic        clk;
    logic        rst;
    logic [2:0]  irq_src;
    logic        ie_set;
    logic        ie_clr;
    logic        uret;
    logic        take_ok;
    logic [31:0] pc_commit;
    logic        irq_take;
    logic [31:0] irq_vector;
    logic [31:0] epc;
    logic        ie;
    logic        in_service;
    logic [1:0]  cur_src;
    logic [2:0]  pending;
`ifdef NESTED_IRQ_EN
    logic [1:0]  depth;
    localparam logic IE_AFTER_TAKE = 1'b1;
`else
    localparam logic IE_AFTER_TAKE = 1'b0;
`endif

    int vectors;
    int miscompares;

    irq_controller #(
        .NUM_SRC(3),
        .VEC_BASE(32'h0000_1000),
        .VEC_STRIDE(32'h0000_0040)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_src(irq_src),
        .ie_set(ie_set),
        .ie_clr(ie_clr),
        .uret(uret),
        .take_ok(take_ok),
        .pc_commit(pc_commit),
        .irq_take(irq_take),
        .irq_vector(irq_vector),
        .epc(epc),
        .ie(ie),
        .in_service(in_service),
        .cur_src(cur_src),
        .pending(pending)
`ifdef NESTED_IRQ_EN
        ,
        .depth(depth)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq_take === 1'b1) begin
            $display("take src=%0d vector=%h epc=%h pending=%b", cur_src, irq_vector, epc, pending);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (irq_take !== 1'b0) begin miscompares++; $display("FAIL reset_take got=%b exp=0", irq_take); end
        vectors++; if (irq_vector !== 32'h0) begin miscompares++; $display("FAIL reset_vector got=%h exp=0", irq_vector); end
        vectors++; if (epc !== 32'h0) begin miscompares++; $display("FAIL reset_epc got=%h exp=0", epc); end
        vectors++; if (ie !== 1'b0) begin miscompares++; $display("FAIL reset_ie got=%b exp=0", ie); end
        vectors++; if (in_service !== 1'b0) begin miscompares++; $display("FAIL reset_in_service got=%b exp=0", in_service); end
        vectors++; if (cur_src !== 2'd0) begin miscompares++; $display("FAIL reset_cur_src got=%0d exp=0", cur_src); end
        vectors++; if (pending !== 3'b000) begin miscompares++; $display("FAIL reset_pending got=%b exp=000", pending); end
        rst = 1'b0;
    endtask

    task automatic test_basic_take;
        ie_set = 1'b1;
        tick();
        ie_set = 1'b0;
        vectors++; if (ie !== 1'b1) begin miscompares++; $display("FAIL basic_ie_set got=%b exp=1", ie); end
        irq_src   = 3'b010;
        pc_commit = 32'h0000_002C;
        tick();
        vectors++; if (pending !== 3'b010) begin miscompares++; $display("FAIL basic_pending got=%b exp=010", pending); end
        vectors++; if (irq_take !== 1'b0) begin miscompares++; $display("FAIL basic_early_take got=%b exp=0", irq_take); end
        take_ok = 1'b1;
        tick();
        vectors++; if (irq_take !== 1'b1) begin miscompares++; $display("FAIL basic_take got=%b exp=1", irq_take); end
        vectors++; if (irq_vector !== 32'h0000_1040) begin miscompares++; $display("FAIL basic_vector got=%h exp=00001040", irq_vector); end
        vectors++; if (epc !== 32'h0000_002C) begin miscompares++; $display("FAIL basic_epc got=%h exp=0000002c", epc); end
        vectors++; if (ie !== IE_AFTER_TAKE) begin miscompares++; $display("FAIL basic_ie_entry got=%b exp=%b", ie, IE_AFTER_TAKE); end
        vectors++; if (in_service !== 1'b1) begin miscompares++; $display("FAIL basic_in_service got=%b exp=1", in_service); end
        vectors++; if (cur_src !== 2'd1) begin miscompares++; $display("FAIL basic_cur_src got=%0d exp=1", cur_src); end
        vectors++; if (pending !== 3'b000) begin miscompares++; $display("FAIL basic_pending_clr got=%b exp=000", pending); end
        take_ok = 1'b0;
        irq_src = 3'b000;
        tick();
        vectors++; if (irq_take !== 1'b0) begin miscompares++; $display("FAIL basic_pulse got=%b exp=0", irq_take); end
        vectors++; if (irq_vector !== 32'h0000_1040) begin miscompares++; $display("FAIL basic_vector_hold got=%h exp=00001040", irq_vector); end
        uret = 1'b1;
        tick();
        uret = 1'b0;
        vectors++; if (in_service !== 1'b0) begin miscompares++; $display("FAIL basic_uret_idle got=%b exp=0", in_service); end
        vectors++; if (ie !== 1'b1) begin miscompares++; $display("FAIL basic_uret_ie got=%b exp=1", ie); end
        vectors++; if (cur_src !== 2'd1) begin miscompares++; $display("FAIL basic_cur_src_hold got=%0d exp=1", cur_src); end
    endtask

    task automatic test_priority;
        irq_src = 3'b101;
        tick();
        vectors++; if (pending !== 3'b101) begin miscompares++; $display("FAIL prio_pending got=%b exp=101", pending); end
        take_ok = 1'b1;
        tick();
        vectors++; if (irq_take !== 1'b1) begin miscompares++; $display("FAIL prio_take0 got=%b exp=1", irq_take); end
        vectors++; if (irq_vector !== 32'h0000_1000) begin miscompares++; $display("FAIL prio_vector0 got=%h exp=00001000", irq_vector); end
        vectors++; if (cur_src !== 2'd0) begin miscompares++; $display("FAIL prio_cur_src0 got=%0d exp=0", cur_src); end
        vectors++; if (pending !== 3'b100) begin miscompares++; $display("FAIL prio_pending_left got=%b exp=100", pending); end
        tick();
        vectors++; if (irq_take !== 1'b0) begin miscompares++; $display("FAIL prio_no_retake got=%b exp=0", irq_take); end
        vectors++; if (pending !== 3'b100) begin miscompares++; $display("FAIL prio_pending_held got=%b exp=100", pending); end
        irq_src = 3'b000;
        uret    = 1'b1;
        tick();
        uret = 1'b0;
        vectors++; if (ie !== 1'b1) begin miscompares++; $display("FAIL prio_uret_ie got=%b exp=1", ie); end
        vectors++; if (irq_take !== 1'b0) begin miscompares++; $display("FAIL prio_uret_cycle_take got=%b exp=0", irq_take); end
        tick();
        vectors++; if (irq_take !== 1'b1) begin miscompares++; $display("FAIL prio_take2 got=%b exp=1", irq_take); end
        vectors++; if (irq_vector !== 32'h0000_1080) begin miscompares++; $display("FAIL prio_vector2 got=%h exp=00001080", irq_vector); end
        vectors++; if (cur_src !== 2'd2) begin miscompares++; $display("FAIL prio_cur_src2 got=%0d exp=2", cur_src); end
        take_ok = 1'b0;
        uret    = 1'b1;
        tick();
        uret = 1'b0;
        vectors++; if (in_service !== 1'b0) begin miscompares++; $display("FAIL prio_final_idle got=%b exp=0", in_service); end
    endtask

    task automatic test_blocking;
        int takes;
        ie_clr = 1'b1;
        tick();
        ie_clr = 1'b0;
        vectors++; if (ie !== 1'b0) begin miscompares++; $display("FAIL block_ie_clr got=%b exp=0", ie); end
        irq_src = 3'b010;
        tick();
        vectors++; if (pending !== 3'b010) begin miscompares++; $display("FAIL block_pending got=%b exp=010", pending); end
        take_ok = 1'b1;
        takes   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (irq_take !== 1'b0) takes++;
        end
        vectors++; if (takes !== 0) begin miscompares++; $display("FAIL block_ie0_takes got=%0d exp=0", takes); end
        vectors++; if (pending !== 3'b010) begin miscompares++; $display("FAIL block_ie0_pending got=%b exp=010", pending); end
        take_ok = 1'b0;
        ie_set  = 1'b1;
        tick();
        ie_set = 1'b0;
        vectors++; if (ie !== 1'b1) begin miscompares++; $display("FAIL block_ie_set got=%b exp=1", ie); end
        takes = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (irq_take !== 1'b0) takes++;
        end
        vectors++; if (takes !== 0) begin miscompares++; $display("FAIL block_takeok0_takes got=%0d exp=0", takes); end
        take_ok = 1'b1;
        tick();
        vectors++; if (irq_take !== 1'b1) begin miscompares++; $display("FAIL block_late_take got=%b exp=1", irq_take); end
        vectors++; if (irq_vector !== 32'h0000_1040) begin miscompares++; $display("FAIL block_late_vector got=%h exp=00001040", irq_vector); end
        take_ok = 1'b0;
        uret    = 1'b1;
        tick();
        uret = 1'b0;
        tick();
        vectors++; if (pending !== 3'b000) begin miscompares++; $display("FAIL block_level_retrigger got=%b exp=000", pending); end
        irq_src = 3'b000;
    endtask

    task automatic test_corners;
        ie_clr = 1'b1;
        tick();
        ie_clr = 1'b0;
        uret   = 1'b1;
        tick();
        uret = 1'b0;
        vectors++; if (ie !== 1'b0) begin miscompares++; $display("FAIL corner_uret_idle_ie got=%b exp=0", ie); end
        vectors++; if (in_service !== 1'b0) begin miscompares++; $display("FAIL corner_uret_idle_state got=%b exp=0", in_service); end
        ie_set = 1'b1;
        ie_clr = 1'b1;
        tick();
        vectors++; if (ie !== 1'b0) begin miscompares++; $display("FAIL corner_both_from0 got=%b exp=0", ie); end
        ie_clr = 1'b0;
        tick();
        ie_clr = 1'b1;
        tick();
        ie_set = 1'b0;
        ie_clr = 1'b0;
        vectors++; if (ie !== 1'b0) begin miscompares++; $display("FAIL corner_both_from1 got=%b exp=0", ie); end
        irq_src = 3'b001;
        ie_set  = 1'b1;
        tick();
        ie_set = 1'b0;
        vectors++; if (pending !== 3'b001) begin miscompares++; $display("FAIL corner_pending0 got=%b exp=001", pending); end
        irq_src = 3'b000;
        tick();
        irq_src = 3'b001;
        take_ok = 1'b1;
        tick();
        vectors++; if (irq_take !== 1'b1) begin miscompares++; $display("FAIL corner_clear_take got=%b exp=1", irq_take); end
        vectors++; if (irq_vector !== 32'h0000_1000) begin miscompares++; $display("FAIL corner_clear_vector got=%h exp=00001000", irq_vector); end
        vectors++; if (pending !== 3'b001) begin miscompares++; $display("FAIL corner_edge_on_clear got=%b exp=001", pending); end
        take_ok = 1'b0;
        irq_src = 3'b000;
        uret    = 1'b1;
        tick();
        uret    = 1'b0;
        take_ok = 1'b1;
        tick();
        take_ok = 1'b0;
        uret    = 1'b1;
        tick();
        uret = 1'b0;
        vectors++; if (pending !== 3'b000) begin miscompares++; $display("FAIL corner_drain got=%b exp=000", pending); end
    endtask

    task automatic test_reset_mid_service;
        irq_src = 3'b010;
        tick();
        take_ok = 1'b1;
        tick();
        take_ok = 1'b0;
        vectors++; if (in_service !== 1'b1) begin miscompares++; $display("FAIL rstmid_entry got=%b exp=1", in_service); end
        irq_src = 3'b011;
        tick();
        vectors++; if (pending !== 3'b001) begin miscompares++; $display("FAIL rstmid_latch_in_service got=%b exp=001", pending); end
        rst     = 1'b1;
        irq_src = 3'b001;
        tick();
        tick();
        vectors++; if (in_service !== 1'b0) begin miscompares++; $display("FAIL rstmid_state got=%b exp=0", in_service); end
        vectors++; if (pending !== 3'b000) begin miscompares++; $display("FAIL rstmid_pending got=%b exp=000", pending); end
        vectors++; if (ie !== 1'b0) begin miscompares++; $display("FAIL rstmid_ie got=%b exp=0", ie); end
        vectors++; if (epc !== 32'h0) begin miscompares++; $display("FAIL rstmid_epc got=%h exp=0", epc); end
        rst     = 1'b0;
        take_ok = 1'b1;
        tick();
        take_ok = 1'b0;
        vectors++; if (pending !== 3'b001) begin miscompares++; $display("FAIL rstmid_held_line got=%b exp=001", pending); end
        vectors++; if (irq_take !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_take got=%b exp=0", irq_take); end
    endtask

`ifdef NESTED_IRQ_EN
    task automatic test_nesting;
        rst     = 1'b1;
        irq_src = 3'b000;
        tick();
        rst    = 1'b0;
        ie_set = 1'b1;
        tick();
        ie_set    = 1'b0;
        pc_commit = 32'h0000_0040;
        irq_src   = 3'b100;
        tick();
        take_ok = 1'b1;
        tick();
        vectors++; if (depth !== 2'd1) begin miscompares++; $display("FAIL nest_depth1 got=%0d exp=1", depth); end
        pc_commit = 32'h0000_1088;
        irq_src   = 3'b101;
        tick();
        vectors++; if (irq_take !== 1'b0) begin miscompares++; $display("FAIL nest_gap got=%b exp=0", irq_take); end
        tick();
        vectors++; if (irq_vector !== 32'h0000_1000) begin miscompares++; $display("FAIL nest_vector got=%h exp=00001000", irq_vector); end
        vectors++; if (depth !== 2'd2) begin miscompares++; $display("FAIL nest_depth2 got=%0d exp=2", depth); end
        vectors++; if (epc !== 32'h0000_1088) begin miscompares++; $display("FAIL nest_epc got=%h exp=00001088", epc); end
        take_ok = 1'b0;
        uret    = 1'b1;
        tick();
        vectors++; if (epc !== 32'h0000_0040) begin miscompares++; $display("FAIL nest_pop_epc got=%h exp=00000040", epc); end
        vectors++; if (cur_src !== 2'd2) begin miscompares++; $display("FAIL nest_pop_src got=%0d exp=2", cur_src); end
        vectors++; if (depth !== 2'd1) begin miscompares++; $display("FAIL nest_pop_depth got=%0d exp=1", depth); end
        tick();
        uret = 1'b0;
        vectors++; if (in_service !== 1'b0) begin miscompares++; $display("FAIL nest_final_idle got=%b exp=0", in_service); end
        vectors++; if (depth !== 2'd0) begin miscompares++; $display("FAIL nest_final_depth got=%0d exp=0", depth); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        irq_src     = 3'b000;
        ie_set      = 1'b0;
        ie_clr      = 1'b0;
        uret        = 1'b0;
        take_ok     = 1'b0;
        pc_commit   = 32'h0;
        test_reset();
        test_basic_take();
        test_priority();
        test_blocking();
        test_corners();
        test_reset_mid_service();
`ifdef NESTED_IRQ_EN
        test_nesting();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
